// File: rtl/mem_arbiter_if.sv
// Bundles the icache, dcache and memory-side signals of mem_arbiter.
// slave = arbiter side, master = the caches/memory environment side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              ic_read;
  logic [ADDR_W-1:0] ic_address;
  logic [DATA_W-1:0] ic_readdata;
  logic              ic_busywait;

  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_address;
  logic [DATA_W-1:0] dc_writedata;
  logic [DATA_W-1:0] dc_readdata;
  logic              dc_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  ic_read, ic_address,
    output ic_readdata, ic_busywait,
    input  dc_read, dc_write, dc_address, dc_writedata,
    output dc_readdata, dc_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output ic_read, ic_address,
    input  ic_readdata, ic_busywait,
    output dc_read, dc_write, dc_address, dc_writedata,
    input  dc_readdata, dc_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter serialising block transfers to one memory.
// Define ARB_ROUND_ROBIN_EN for round-robin on collisions; default is dcache-priority.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_IC = 1'b0;
  localparam logic PORT_DC = 1'b1;

  state_t            state_r, state_s;
  logic              grant_r, grant_s;
  logic              first_r, first_s;
  logic              mem_read_r, mem_read_s;
  logic              mem_write_r, mem_write_s;
  logic [ADDR_W-1:0] mem_address_r, mem_address_s;
  logic [DATA_W-1:0] mem_writedata_r, mem_writedata_s;
  logic [DATA_W-1:0] ic_readdata_r, ic_readdata_s;
  logic [DATA_W-1:0] dc_readdata_r, dc_readdata_s;
  logic              ic_req_s, dc_req_s, pick_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_r, last_s;
`endif

  assign ic_req_s = bus.ic_read;
  assign dc_req_s = bus.dc_read | bus.dc_write;

  // Stall is combinational so a new request stalls its cache in the same cycle.
  assign bus.ic_busywait = ic_req_s & (RESET | ~((state_r == ST_DONE) & (grant_r == PORT_IC)));
  assign bus.dc_busywait = dc_req_s & (RESET | ~((state_r == ST_DONE) & (grant_r == PORT_DC)));

  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_writedata = mem_writedata_r;
  assign bus.ic_readdata   = ic_readdata_r;
  assign bus.dc_readdata   = dc_readdata_r;

  // Arbitration choice, next-state and next-register values.
  always_comb begin
    state_s         = state_r;
    grant_s         = grant_r;
    first_s         = first_r;
    mem_read_s      = mem_read_r;
    mem_write_s     = mem_write_r;
    mem_address_s   = mem_address_r;
    mem_writedata_s = mem_writedata_r;
    ic_readdata_s   = ic_readdata_r;
    dc_readdata_s   = dc_readdata_r;
`ifdef ARB_ROUND_ROBIN_EN
    last_s = last_r;
    if (ic_req_s && dc_req_s) begin
      pick_s = ~last_r;
    end else if (dc_req_s) begin
      pick_s = PORT_DC;
    end else begin
      pick_s = PORT_IC;
    end
`else
    if (dc_req_s) begin
      pick_s = PORT_DC;
    end else begin
      pick_s = PORT_IC;
    end
`endif

    case (state_r)
      ST_IDLE: begin
        if (ic_req_s || dc_req_s) begin
          state_s = ST_ACCESS;
          grant_s = pick_s;
          first_s = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_s  = pick_s;
`endif
          // A simultaneous read+write from the dcache is served as a write.
          if (pick_s == PORT_DC) begin
            mem_read_s      = ~bus.dc_write;
            mem_write_s     = bus.dc_write;
            mem_address_s   = bus.dc_address;
            mem_writedata_s = bus.dc_writedata;
          end else begin
            mem_read_s      = 1'b1;
            mem_write_s     = 1'b0;
            mem_address_s   = bus.ic_address;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        first_s = 1'b0;
        // The first ACCESS cycle ignores mem_busywait: memory may raise it a cycle late.
        if (!first_r && !bus.mem_busywait) begin
          if (mem_read_r && (grant_r == PORT_DC)) begin
            dc_readdata_s = bus.mem_readdata;
          end else if (mem_read_r) begin
            ic_readdata_s = bus.mem_readdata;
          end else begin
            ic_readdata_s = ic_readdata_r;
          end
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r         <= ST_IDLE;
      grant_r         <= PORT_IC;
      first_r         <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= {ADDR_W{1'b0}};
      mem_writedata_r <= {DATA_W{1'b0}};
      ic_readdata_r   <= {DATA_W{1'b0}};
      dc_readdata_r   <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_r          <= PORT_IC;
`endif
    end else begin
      state_r         <= state_s;
      grant_r         <= grant_s;
      first_r         <= first_s;
      mem_read_r      <= mem_read_s;
      mem_write_r     <= mem_write_s;
      mem_address_r   <= mem_address_s;
      mem_writedata_r <= mem_writedata_s;
      ic_readdata_r   <= ic_readdata_s;
      dc_readdata_r   <= dc_readdata_s;
`ifdef ARB_ROUND_ROBIN_EN
      last_r          <= last_s;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request pairs, checked cycle by cycle against a transaction-level schedule model.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus();
  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n_busy = 1;

  // Background pattern of never-written memory blocks.
  function automatic logic [31:0] init_pat(input logic [5:0] a);
    return {a, 2'b01, a, 2'b10, a, 4'hC, a};
  endfunction

  // Memory: busywait stays high until the strobe has been seen for n_busy cycles.
  logic [31:0] mem_arr [64];
  bit          mem_wr  [64];
  int          acc_cnt = 0;
  always @(negedge CLK) begin
    if (bus.mem_read || bus.mem_write) begin
      acc_cnt <= acc_cnt + 1;
      bus.mem_busywait <= (acc_cnt + 1 < n_busy);
      if (bus.mem_write && !(acc_cnt + 1 < n_busy)) begin
        mem_arr[bus.mem_address] <= bus.mem_writedata;
        mem_wr[bus.mem_address]  <= 1'b1;
      end
    end else begin
      acc_cnt <= 0;
      bus.mem_busywait <= 1'b0;
    end
    bus.mem_readdata <= mem_wr[bus.mem_address] ? mem_arr[bus.mem_address] : init_pat(bus.mem_address);
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  bit          ref_wr  [64];
  logic [31:0] exp_ic_rd, exp_dc_rd;
  bit          last_dc;

  function automatic logic [31:0] ref_read(input logic [5:0] a);
    return ref_wr[a] ? ref_mem[a] : init_pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_ic_rd = 32'd0;
    exp_dc_rd = 32'd0;
    last_dc   = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; cycle 0 is the current cycle.
  task automatic run_txn(input bit ic_en, input int ic_arr, input logic [5:0] ic_addr,
                         input bit dc_en, input int dc_arr, input bit dc_wr,
                         input logic [5:0] dc_addr, input logic [31:0] dc_data, input int nb);
    int a_len, t, free, last_cycle;
    int start_ic, start_dc, done_ic, done_dc;
    bit served_ic, served_dc, cand_ic, cand_dc, pick_dc;
    bit e_bw_ic, e_bw_dc, in_ic, in_dc;
    logic [31:0] ic_val, dc_val, e_ic, e_dc;
    n_busy    = nb;
    a_len     = (nb > 2) ? nb : 2;
    served_ic = !ic_en;
    served_dc = !dc_en;
    free = 0; start_ic = -100; start_dc = -100; done_ic = -1; done_dc = -1;
    ic_val = exp_ic_rd; dc_val = exp_dc_rd;
    while (!(served_ic && served_dc)) begin
      t = free;
      if (!served_ic && !served_dc) begin
        if (t < ic_arr && t < dc_arr) t = (ic_arr < dc_arr) ? ic_arr : dc_arr;
      end else if (!served_ic) begin
        if (t < ic_arr) t = ic_arr;
      end else begin
        if (t < dc_arr) t = dc_arr;
      end
      cand_ic = !served_ic && (ic_arr <= t);
      cand_dc = !served_dc && (dc_arr <= t);
`ifdef ARB_ROUND_ROBIN_EN
      if (cand_ic && cand_dc) pick_dc = !last_dc;
      else pick_dc = cand_dc;
`else
      pick_dc = cand_dc;
`endif
      last_dc = pick_dc;
      if (pick_dc) begin
        start_dc = t + 1; done_dc = t + 1 + a_len; served_dc = 1'b1; free = done_dc + 1;
      end else begin
        start_ic = t + 1; done_ic = t + 1 + a_len; served_ic = 1'b1; free = done_ic + 1;
      end
    end
    // Apply memory effects in service order.
    if (dc_en && (!ic_en || start_dc < start_ic)) begin
      if (dc_wr) begin ref_mem[dc_addr] = dc_data; ref_wr[dc_addr] = 1'b1; end
      else dc_val = ref_read(dc_addr);
      if (ic_en) ic_val = ref_read(ic_addr);
    end else begin
      if (ic_en) ic_val = ref_read(ic_addr);
      if (dc_en && dc_wr) begin ref_mem[dc_addr] = dc_data; ref_wr[dc_addr] = 1'b1; end
      else if (dc_en) dc_val = ref_read(dc_addr);
    end
    last_cycle = (done_ic > done_dc) ? done_ic : done_dc;
    for (int c = 0; c <= last_cycle; c++) begin
      bus.ic_read      = ic_en && c >= ic_arr && c <= done_ic;
      bus.dc_read      = dc_en && !dc_wr && c >= dc_arr && c <= done_dc;
      bus.dc_write     = dc_en && dc_wr && c >= dc_arr && c <= done_dc;
      bus.ic_address   = ic_addr;
      bus.dc_address   = dc_addr;
      bus.dc_writedata = dc_data;
      @(negedge CLK);
      e_bw_ic = ic_en && c >= ic_arr && c < done_ic;
      e_bw_dc = dc_en && c >= dc_arr && c < done_dc;
      in_ic   = ic_en && c >= start_ic && c < start_ic + a_len;
      in_dc   = dc_en && c >= start_dc && c < start_dc + a_len;
      e_ic    = (ic_en && c >= done_ic) ? ic_val : exp_ic_rd;
      e_dc    = (dc_en && !dc_wr && c >= done_dc) ? dc_val : exp_dc_rd;
      chk("ic_busywait", 32'(bus.ic_busywait), 32'(e_bw_ic));
      chk("dc_busywait", 32'(bus.dc_busywait), 32'(e_bw_dc));
      chk("mem_read", 32'(bus.mem_read), 32'(in_ic || (in_dc && !dc_wr)));
      chk("mem_write", 32'(bus.mem_write), 32'(in_dc && dc_wr));
      if (in_ic) chk("mem_address_ic", 32'(bus.mem_address), 32'(ic_addr));
      if (in_dc) chk("mem_address_dc", 32'(bus.mem_address), 32'(dc_addr));
      if (in_dc && dc_wr) chk("mem_writedata", bus.mem_writedata, dc_data);
      chk("ic_readdata", bus.ic_readdata, e_ic);
      chk("dc_readdata", bus.dc_readdata, e_dc);
      @(posedge CLK); #1;
    end
    bus.ic_read  = 1'b0;
    bus.dc_read  = 1'b0;
    bus.dc_write = 1'b0;
    exp_ic_rd = ic_val;
    exp_dc_rd = dc_val;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_wr[i] = 1'b0;
    // Reset held two cycles while the icache already requests.
    RESET            = 1'b1;
    bus.ic_read      = 1'b1;
    bus.ic_address   = 6'h2A;
    bus.dc_read      = 1'b0;
    bus.dc_write     = 1'b0;
    bus.dc_address   = 6'h00;
    bus.dc_writedata = 32'd0;
    @(negedge CLK);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
    chk("rst_ic_readdata", bus.ic_readdata, 32'd0);
    chk("rst_dc_readdata", bus.dc_readdata, 32'd0);
    chk("rst_ic_busywait", 32'(bus.ic_busywait), 32'd1);
    chk("rst_dc_busywait", 32'(bus.dc_busywait), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    run_txn(1'b1, 0, 6'h2A, 1'b0, 0, 1'b0, 6'h00, 32'd0, 3);

    // dcache write-back, then seed 0x05 for the icache read test.
    run_txn(1'b0, 0, 6'h00, 1'b1, 0, 1'b1, 6'h12, 32'hA5A5A5A5, 2);
    run_txn(1'b0, 0, 6'h00, 1'b1, 0, 1'b1, 6'h05, 32'hDEADBEEF, 1);

    // icache read with a 5-cycle memory: stall drops in the 7th cycle.
    run_txn(1'b1, 0, 6'h05, 1'b0, 0, 1'b0, 6'h00, 32'd0, 5);
    chk("t2_ic_readdata", bus.ic_readdata, 32'hDEADBEEF);

    // Collisions straight after reset.
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    run_txn(1'b1, 0, 6'h01, 1'b1, 0, 1'b0, 6'h02, 32'd0, 2);
    run_txn(1'b1, 0, 6'h01, 1'b1, 0, 1'b0, 6'h02, 32'd0, 2);

    // dcache read arriving while the icache transfer is in ACCESS.
    run_txn(1'b1, 0, 6'h07, 1'b1, 2, 1'b0, 6'h12, 32'd0, 4);
    chk("t5_dc_readdata", bus.dc_readdata, 32'hA5A5A5A5);

    // Reset in the third ACCESS cycle aborts the transfer.
    bus.ic_read    = 1'b1;
    bus.ic_address = 6'h33;
    n_busy         = 6;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t6_ic_busywait", 32'(bus.ic_busywait), 32'd1);
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    @(negedge CLK);
    chk("t6_mem_read_before", 32'(bus.mem_read), 32'd1);
    chk("t6_busywait_in_rst", 32'(bus.ic_busywait), 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    run_txn(1'b1, 0, 6'h33, 1'b0, 0, 1'b0, 6'h00, 32'd0, 6);

    // Randomized request pairs over a small address range to force reuse.
    for (int i = 0; i < 40; i++) begin
      bit ie, de, dw;
      ie = 1'($urandom_range(0, 1));
      de = ie ? 1'($urandom_range(0, 1)) : 1'b1;
      dw = 1'($urandom_range(0, 1));
      run_txn(ie, int'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
              de, int'($urandom_range(0, 3)), dw, 6'($urandom_range(0, 7)),
              $urandom, int'($urandom_range(1, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
